// File: rtl/rx_sync_ctrl_pkg.sv
// rx_sync_ctrl_pkg: state encoding and default sizing shared by the sequencer and its bench
package rx_sync_ctrl_pkg;
  typedef enum logic [2:0] {
    S_FLUSH        = 3'd0,
    S_SEARCH_SHORT = 3'd1,
    S_WAIT_LONG    = 3'd2,
    S_LOCKED       = 3'd3
  } state_t;
  localparam int DEF_LONG_TIMEOUT = 320;
  localparam int DEF_FLUSH_LEN    = 16;
  localparam int DEF_CNT_WIDTH    = 32;
endpackage

// File: rtl/rx_sync_ctrl_sat_counter.sv
// sat_counter: loadable down-counter that sticks at zero and flags terminal count
module sat_counter #(
  parameter int           W       = 8,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         i_clock,
  input  logic         i_reset,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_dec,
  output logic [W-1:0] o_cnt,
  output logic         o_tc
);
  logic [W-1:0] r_cnt;
  always_ff @(posedge i_clock) begin
    if (i_reset) r_cnt <= RST_VAL;
    else if (i_load) r_cnt <= i_load_val;
    else if (i_dec && r_cnt != '0) r_cnt <= r_cnt - W'(1);
  end
  assign o_cnt = r_cnt;
  assign o_tc  = r_cnt == '0;
endmodule

// File: rtl/rx_sync_ctrl.sv
// rx_sync_ctrl: sequences short/long preamble synchronisers and latches the coarse phase offset
import rx_sync_ctrl_pkg::*;
module rx_sync_ctrl #(
  parameter int LONG_TIMEOUT = DEF_LONG_TIMEOUT,
  parameter int FLUSH_LEN    = DEF_FLUSH_LEN,
  parameter int CNT_WIDTH    = DEF_CNT_WIDTH
) (
  input  logic                 i_clock,
  input  logic                 i_reset,
  input  logic                 i_enable,
  input  logic                 i_sample_in_strobe,
  input  logic                 i_short_preamble_detected,
  input  logic signed [15:0]   i_phase_offset,
  input  logic                 i_long_preamble_detected,
  input  logic                 i_pkt_done,
  output logic                 o_sync_short_reset,
  output logic                 o_sync_short_enable,
  output logic                 o_sync_long_reset,
  output logic                 o_sync_long_enable,
  output logic signed [15:0]   o_phase_offset_out,
  output logic                 o_locked,
  output logic [2:0]           o_state,
  output logic [CNT_WIDTH-1:0] o_short_cnt,
  output logic [CNT_WIDTH-1:0] o_timeout_cnt
);
  localparam int FW = $clog2(FLUSH_LEN + 1);
  localparam int TW = $clog2(LONG_TIMEOUT + 1);
  state_t                r_state;
  logic                  r_short_reset, r_short_en, r_long_reset, r_long_en, r_locked;
  logic signed [15:0]    r_offset;
  logic [CNT_WIDTH-1:0]  r_short_cnt, r_timeout_cnt;
  logic                  w_flush_tc, w_tmo_tc;
  logic                  w_flush_done, w_short_acc, w_long_acc, w_timeout, w_pkt_end;
  logic [FW-1:0]         w_flush_cnt;
  logic [TW-1:0]         w_tmo_cnt;
  state_t                w_next;
  assign w_flush_done = r_state == S_FLUSH && w_flush_tc;
  assign w_short_acc  = r_state == S_SEARCH_SHORT && i_short_preamble_detected;
  assign w_long_acc   = r_state == S_WAIT_LONG && i_long_preamble_detected;
  // the strobe that finds the down-counter already at zero is the LONG_TIMEOUT-th one
  assign w_timeout    = r_state == S_WAIT_LONG && i_sample_in_strobe && w_tmo_tc && !i_long_preamble_detected;
  assign w_pkt_end    = r_state == S_LOCKED && i_pkt_done;
  assign w_next = w_flush_done ? S_SEARCH_SHORT :
                  w_short_acc  ? S_WAIT_LONG :
                  w_long_acc   ? S_LOCKED :
                  (w_timeout || w_pkt_end) ? S_FLUSH : r_state;
  sat_counter #(.W(FW), .RST_VAL(FW'(FLUSH_LEN - 1))) u_flush_cnt (
    .i_clock    (i_clock),
    .i_reset    (i_reset),
    .i_load     (i_enable && (w_timeout || w_pkt_end)),
    .i_load_val (FW'(FLUSH_LEN - 1)),
    .i_dec      (i_enable && r_state == S_FLUSH),
    .o_cnt      (w_flush_cnt),
    .o_tc       (w_flush_tc)
  );
  sat_counter #(.W(TW), .RST_VAL('0)) u_tmo_cnt (
    .i_clock    (i_clock),
    .i_reset    (i_reset),
    .i_load     (i_enable && w_short_acc),
    .i_load_val (TW'(LONG_TIMEOUT - 1)),
    .i_dec      (i_enable && r_state == S_WAIT_LONG && i_sample_in_strobe),
    .o_cnt      (w_tmo_cnt),
    .o_tc       (w_tmo_tc)
  );
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state       <= S_FLUSH;
      r_short_reset <= 1'b1;
      r_short_en    <= 1'b0;
      r_long_reset  <= 1'b1;
      r_long_en     <= 1'b0;
      r_locked      <= 1'b0;
      r_offset      <= '0;
      r_short_cnt   <= '0;
      r_timeout_cnt <= '0;
    end else if (!i_enable) begin
      r_short_en <= 1'b0;
      r_long_en  <= 1'b0;
    end else begin
      r_state       <= w_next;
      r_short_reset <= w_next == S_FLUSH;
      r_short_en    <= w_next == S_SEARCH_SHORT;
      r_long_reset  <= w_next == S_FLUSH || w_next == S_SEARCH_SHORT;
      r_long_en     <= w_next == S_WAIT_LONG || w_next == S_LOCKED;
      r_locked      <= w_next == S_LOCKED;
      if (w_short_acc) r_offset <= i_phase_offset;
      if (w_short_acc) r_short_cnt <= r_short_cnt + CNT_WIDTH'(1);
      if (w_timeout) r_timeout_cnt <= r_timeout_cnt + CNT_WIDTH'(1);
    end
  end
  assign o_sync_short_reset  = r_short_reset;
  assign o_sync_short_enable = r_short_en;
  assign o_sync_long_reset   = r_long_reset;
  assign o_sync_long_enable  = r_long_en;
  assign o_phase_offset_out  = r_offset;
  assign o_locked            = r_locked;
  assign o_state             = r_state;
  assign o_short_cnt         = r_short_cnt;
  assign o_timeout_cnt       = r_timeout_cnt;
endmodule
